multiword_add_sequencer: RTL and testbench

Streaming multi-precision add/subtract engine that drives the team's N-bit combinational carry-lookahead adder. It accepts wide operands as a little-endian sequence of N-bit word pairs over a valid/ready handshake. It chains the adder carry-out into the next word's carry-in through a register, and emits one registered result word per accepted input word. It sits directly upstream of the adder, feeding `a`, `b` and `ci`, and directly downstream of it, consuming `c` and `co`, inside the FixedPointArithmetic datapath.

---
 rtl/multiword_add_sequencer.sv | 179 +++++++++++++++++
 tb/tb_multiword_add_sequencer.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/multiword_add_sequencer.sv
// Streaming multi-precision add/subtract sequencer around an N-bit adder.
// A wide operand arrives as little-endian N-bit word pairs over valid/ready.
// Each word's adder carry-out is registered and chained into the next word,
// and one registered result word is produced per accepted input beat.
// Ports:
//   clk, rst                      clock, async active-high reset
//   in_valid/in_ready             input handshake (in_ready depends only on output side)
//   in_a, in_b                    operand words
//   in_first, in_last             operation framing
//   in_ci, in_sub                 external carry-in (add only), subtract select
//   out_valid/out_ready           output handshake
//   out_c, out_idx, out_last      result word, word index, final-word flag
//   out_co, out_ovf               final carry (sub: 1 = no borrow), signed overflow
//   out_err                       protocol error on this beat

// N-bit adder in generate/propagate form.
module cla_adder #(
  parameter int unsigned N = 32
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         ci,
  output logic [N-1:0] c,
  output logic         co
);
  always_comb begin : carry_net
    logic cy;
    cy = ci;
    c  = '0;
    for (int i = 0; i < int'(N); i++) begin
      c[i] = a[i] ^ b[i] ^ cy;
      cy   = (a[i] & b[i]) | ((a[i] ^ b[i]) & cy);
    end
    co = cy;
  end
endmodule

module multiword_add_sequencer #(
  parameter int unsigned N    = 32,
  parameter int unsigned MAXW = 16,
  parameter int unsigned WCW  = $clog2(MAXW + 1)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   in_a,
  input  logic [N-1:0]   in_b,
  input  logic           in_first,
  input  logic           in_last,
  input  logic           in_ci,
  input  logic           in_sub,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [N-1:0]   out_c,
  output logic [WCW-1:0] out_idx,
  output logic           out_last,
  output logic           out_co,
  output logic           out_ovf,
  output logic           out_err
);
  localparam logic [WCW-1:0] LAST_IDX = WCW'(MAXW - 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t         state_q, state_d;
  logic           carry_q, carry_d;
  logic           sub_q, sub_d;
  logic [WCW-1:0] cnt_q, cnt_d;
  logic           out_valid_q, out_valid_d;
  logic [N-1:0]   out_c_q, out_c_d;
  logic [WCW-1:0] out_idx_q, out_idx_d;
  logic           out_last_q, out_last_d;
  logic           out_co_q, out_co_d;
  logic           out_ovf_q, out_ovf_d;
  logic           out_err_q, out_err_d;

  logic           accept;
  logic           start;
  logic           sub_eff;
  logic [N-1:0]   b_eff;
  logic           add_ci;
  logic [WCW-1:0] idx;
  logic [N-1:0]   add_c;
  logic           add_co;

  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  // Operand/carry selection: a beat starts a fresh operation from IDLE or when
  // in_first arrives mid-operation (the open operation is abandoned).
  always_comb begin
    start   = (state_q == IDLE) || in_first;
    sub_eff = start ? in_sub : sub_q;
    b_eff   = sub_eff ? ~in_b : in_b;
    add_ci  = start ? (in_sub | in_ci) : carry_q;
    idx     = start ? '0 : cnt_q;
  end

  cla_adder #(.N(N)) u_adder (
    .a  (in_a),
    .b  (b_eff),
    .ci (add_ci),
    .c  (add_c),
    .co (add_co)
  );

  // Next-state and output-register load.
  always_comb begin
    logic at_max;
    logic last_eff;
    state_d     = state_q;
    carry_d     = carry_q;
    sub_d       = sub_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q && !out_ready;
    out_c_d     = out_c_q;
    out_idx_d   = out_idx_q;
    out_last_d  = out_last_q;
    out_co_d    = out_co_q;
    out_ovf_d   = out_ovf_q;
    out_err_d   = out_err_q;
    at_max      = (idx == LAST_IDX);
    last_eff    = in_last || at_max;

    if (accept) begin
      sub_d       = sub_eff;
      carry_d     = add_co;
      cnt_d       = last_eff ? '0 : idx + WCW'(1);
      state_d     = last_eff ? IDLE : BUSY;
      out_valid_d = 1'b1;
      out_c_d     = add_c;
      out_idx_d   = idx;
      out_last_d  = last_eff;
      out_co_d    = last_eff && add_co;
      // Carry into the MSB is recovered from the MSB sum bit.
      out_ovf_d   = last_eff && ((in_a[N-1] ^ b_eff[N-1] ^ add_c[N-1]) ^ add_co);
      out_err_d   = ((state_q == IDLE) && !in_first) ||
                    ((state_q == BUSY) && in_first) ||
                    (at_max && !in_last);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      carry_q     <= 1'b0;
      sub_q       <= 1'b0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_c_q     <= '0;
      out_idx_q   <= '0;
      out_last_q  <= 1'b0;
      out_co_q    <= 1'b0;
      out_ovf_q   <= 1'b0;
      out_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      carry_q     <= carry_d;
      sub_q       <= sub_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_c_q     <= out_c_d;
      out_idx_q   <= out_idx_d;
      out_last_q  <= out_last_d;
      out_co_q    <= out_co_d;
      out_ovf_q   <= out_ovf_d;
      out_err_q   <= out_err_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_c     = out_c_q;
  assign out_idx   = out_idx_q;
  assign out_last  = out_last_q;
  assign out_co    = out_co_q;
  assign out_ovf   = out_ovf_q;
  assign out_err   = out_err_q;
endmodule

// File: tb/tb_multiword_add_sequencer.sv
// Bench for multiword_add_sequencer at N=8, MAXW=4: an arithmetic reference
// model predicts each output beat; a negedge monitor checks the DUT against it
// every cycle, and directed literal checks pin the observed beats.
module tb_multiword_add_sequencer;
  localparam int unsigned N    = 8;
  localparam int unsigned MAXW = 4;
  localparam int unsigned WCW  = $clog2(MAXW + 1);

  typedef struct packed {
    logic [N-1:0]   c;
    logic [WCW-1:0] idx;
    logic           last;
    logic           co;
    logic           ovf;
    logic           err;
  } beat_t;

  logic           clk, rst;
  logic           in_valid, in_ready;
  logic [N-1:0]   in_a, in_b;
  logic           in_first, in_last, in_ci, in_sub;
  logic           out_valid, out_ready;
  logic [N-1:0]   out_c;
  logic [WCW-1:0] out_idx;
  logic           out_last, out_co, out_ovf, out_err;

  int n_checks = 0;
  int n_pass   = 0;

  beat_t exp_q[$];
  beat_t obs_q[$];

  // Reference model state (operation-level view)
  logic m_open;
  int   m_idx;
  int   m_carry;
  logic m_sub;

  multiword_add_sequencer #(.N(N), .MAXW(MAXW), .WCW(WCW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b),
    .in_first(in_first), .in_last(in_last), .in_ci(in_ci), .in_sub(in_sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_c(out_c), .out_idx(out_idx), .out_last(out_last),
    .out_co(out_co), .out_ovf(out_ovf), .out_err(out_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] expv);
    n_checks++;
    if (got === expv) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, got, expv, $time);
  endtask

  // Arithmetic prediction of one accepted beat.
  function automatic beat_t predict(input logic [N-1:0] a, input logic [N-1:0] b,
                                    input logic f, input logic l,
                                    input logic ci, input logic s);
    beat_t r;
    logic [N-1:0] bb;
    int cin, us, ss;
    logic first, forced;
    first = !m_open || f;
    r.err = (!m_open && !f) || (m_open && f);
    if (first) begin
      m_idx = 0;
      m_sub = s;
      cin   = s ? 1 : int'(ci);
    end else begin
      cin = m_carry;
    end
    bb = m_sub ? ~b : b;
    us = int'(a) + int'(bb) + cin;
    ss = int'($signed(a)) + int'($signed(bb)) + cin;
    forced = (m_idx == int'(MAXW) - 1) && !l;
    r.err  = r.err || forced;
    r.last = l || forced;
    r.c    = N'(us);
    r.idx  = WCW'(m_idx);
    r.co   = r.last && (us >= (1 << N));
    r.ovf  = r.last && ((ss > (1 << (N - 1)) - 1) || (ss < -(1 << (N - 1))));
    m_carry = (us >= (1 << N)) ? 1 : 0;
    m_open  = !r.last;
    m_idx   = m_idx + 1;
    return r;
  endfunction

  // Per-cycle compare against the model, away from the active edge.
  always @(negedge clk) begin
    if (rst) begin
      chk("rst_out_valid", 32'(out_valid), 0);
      chk("rst_in_ready",  32'(in_ready), 1);
      chk("rst_out_word",  32'({out_c, out_idx, out_last, out_co, out_ovf, out_err}), 0);
      exp_q.delete();
      m_open = 1'b0; m_idx = 0; m_carry = 0; m_sub = 1'b0;
    end else begin
      logic has, pop, acc;
      has = (exp_q.size() != 0);
      chk("in_ready",  32'(in_ready), 32'(!has || out_ready));
      chk("out_valid", 32'(out_valid), 32'(has));
      if (has) begin
        chk("out_c",    32'(out_c),    32'(exp_q[0].c));
        chk("out_idx",  32'(out_idx),  32'(exp_q[0].idx));
        chk("out_last", 32'(out_last), 32'(exp_q[0].last));
        chk("out_co",   32'(out_co),   32'(exp_q[0].co));
        chk("out_ovf",  32'(out_ovf),  32'(exp_q[0].ovf));
        chk("out_err",  32'(out_err),  32'(exp_q[0].err));
      end
      pop = has && out_ready;
      acc = in_valid && (!has || out_ready);
      if (pop) begin
        obs_q.push_back(beat_t'({out_c, out_idx, out_last, out_co, out_ovf, out_err}));
        void'(exp_q.pop_front());
      end
      if (acc) exp_q.push_back(predict(in_a, in_b, in_first, in_last, in_ci, in_sub));
    end
  end

  // Present one beat (called at posedge+1) and hold it until accepted.
  task automatic send(input logic [N-1:0] a, input logic [N-1:0] b,
                      input logic f, input logic l, input logic ci, input logic s);
    logic got;
    in_a = a; in_b = b; in_first = f; in_last = l; in_ci = ci; in_sub = s;
    in_valid = 1'b1;
    got = 1'b0;
    for (int t = 0; t < 50 && !got; t++) begin
      @(negedge clk);
      got = in_ready;
      @(posedge clk);
      #1;
    end
    if (!got) chk("send_timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic chk_obs(input string nm, input int k, input logic [N-1:0] c,
                         input int idx, input logic last, input logic co,
                         input logic ovf, input logic err);
    if (k >= obs_q.size()) begin
      chk({nm, "_missing"}, 32'(obs_q.size()), 32'(k + 1));
    end else begin
      chk({nm, "_c"}, 32'(obs_q[k].c), 32'(c));
      chk({nm, "_flags"}, 32'({obs_q[k].idx, obs_q[k].last, obs_q[k].co, obs_q[k].ovf, obs_q[k].err}),
          32'({WCW'(idx), last, co, ovf, err}));
    end
  endtask

  initial begin
    int base;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    in_a = '0; in_b = '0; in_first = 1'b0; in_last = 1'b0; in_ci = 1'b0; in_sub = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    // Add 0x12FF + 0x0001
    base = obs_q.size();
    send(8'hFF, 8'h01, 1, 0, 0, 0);
    send(8'h12, 8'h00, 0, 1, 0, 0);
    drain();
    chk_obs("add_w0", base,     8'h00, 0, 0, 0, 0, 0);
    chk_obs("add_w1", base + 1, 8'h13, 1, 1, 0, 0, 0);

    // Subtract 0x0100 - 0x0001
    base = obs_q.size();
    send(8'h00, 8'h01, 1, 0, 0, 1);
    send(8'h01, 8'h00, 0, 1, 0, 1);
    drain();
    chk_obs("sub_w0", base,     8'hFF, 0, 0, 0, 0, 0);
    chk_obs("sub_w1", base + 1, 8'h00, 1, 1, 1, 0, 0);

    // Single-word operations
    base = obs_q.size();
    send(8'h7F, 8'h01, 1, 1, 0, 0);
    send(8'hFF, 8'h01, 1, 1, 1, 0);
    drain();
    chk_obs("single_ovf", base,     8'h80, 0, 1, 0, 1, 0);
    chk_obs("single_ci",  base + 1, 8'h01, 0, 1, 1, 0, 0);

    // Backpressure for 3 cycles, then a continuous chained stream
    base = obs_q.size();
    out_ready = 1'b0;
    send(8'hFF, 8'h01, 1, 0, 0, 0);
    fork
      begin
        send(8'hFF, 8'h00, 0, 0, 0, 0);
        send(8'h00, 8'h00, 0, 1, 0, 0);
      end
      begin
        repeat (3) begin
          chk("bp_in_ready", 32'(in_ready), 0);
          @(posedge clk); #1;
        end
        out_ready = 1'b1;
      end
    join
    drain();
    chk_obs("bp_w0", base,     8'h00, 0, 0, 0, 0, 0);
    chk_obs("bp_w1", base + 1, 8'h00, 1, 0, 0, 0, 0);
    chk_obs("bp_w2", base + 2, 8'h01, 2, 1, 0, 0, 0);

    // in_first mid-operation: stale carry (1) must not be used
    base = obs_q.size();
    send(8'hFF, 8'h02, 1, 0, 0, 0);
    send(8'h05, 8'h06, 1, 1, 0, 0);
    drain();
    chk_obs("restart_w0", base,     8'h01, 0, 0, 0, 0, 0);
    chk_obs("restart_w1", base + 1, 8'h0B, 0, 1, 0, 0, 1);

    // Five words with no in_last: forced last at index 3, then a headless start
    base = obs_q.size();
    send(8'h01, 8'h01, 1, 0, 0, 0);
    send(8'h01, 8'h01, 0, 0, 0, 0);
    send(8'h01, 8'h01, 0, 0, 0, 0);
    send(8'h7F, 8'h01, 0, 0, 0, 0);
    send(8'h01, 8'h01, 0, 0, 0, 0);
    send(8'h02, 8'h03, 0, 1, 0, 0);
    drain();
    chk_obs("maxw_w2", base + 2, 8'h02, 2, 0, 0, 0, 0);
    chk_obs("maxw_w3", base + 3, 8'h80, 3, 1, 0, 1, 1);
    chk_obs("maxw_w4", base + 4, 8'h02, 0, 0, 0, 0, 1);
    chk_obs("maxw_w5", base + 5, 8'h05, 1, 1, 0, 0, 0);

    // Reset mid-operation after word 1 of 3
    send(8'h11, 8'h22, 1, 0, 0, 0);
    send(8'h33, 8'h44, 0, 0, 0, 0);
    rst = 1'b1;
    #1;
    chk("async_rst_out_valid", 32'(out_valid), 0);
    chk("async_rst_in_ready",  32'(in_ready), 1);
    @(negedge clk); #2;
    rst = 1'b0;
    @(posedge clk); #1;
    base = obs_q.size();
    send(8'h01, 8'h02, 1, 1, 0, 0);
    drain();
    chk_obs("post_rst", base, 8'h03, 0, 1, 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
